alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters
// Ports: clk/rst (sync active-high); req0_*/req1_* valid/ready/op/a/b request channels;
// alu_op/alu_x/alu_y registered ALU drive, alu_z ALU result; rsp_valid/rsp_ready/rsp_id/
// rsp_data/rsp_err response channel; busy (not IDLE); err_count saturating illegal-op count.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   input  logic [WIDTH-1:0] alu_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic [7:0]       err_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state;
   logic             last;
   logic             gnt;
   logic             acc;
   logic             illegal;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   // On a tie the requester not served last wins; otherwise whoever is valid.
   always_comb begin
      gnt        = (req0_valid && req1_valid) ? ~last : ~req0_valid;
      req0_ready = (state == IDLE) && !gnt && req0_valid;
      req1_ready = (state == IDLE) && gnt && req1_valid;
      acc        = req0_ready || req1_ready;
      op         = gnt ? req1_op : req0_op;
      a          = gnt ? req1_a : req0_a;
      b          = gnt ? req1_b : req0_b;
      illegal    = (op == 4'd4) || (op > 4'd10);
      busy       = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         alu_op    <= '0;
         alu_x     <= '0;
         alu_y     <= '0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: if (acc) begin
               last   <= gnt;
               rsp_id <= gnt;
               if (illegal) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  err_count <= err_count + {7'd0, err_count != 8'hff};
                  state     <= RESP;
               end else begin
                  alu_op <= op;
                  alu_x  <= a;
                  alu_y  <= b;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= alu_z;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  alu_op;
   logic [31:0] alu_x, alu_y, alu_z;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
   logic [31:0] rsp_data;
   logic [7:0]  err_count;
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] alu_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         4'd0:    return x & y;
         4'd1:    return x | y;
         4'd2:    return x + y;
         4'd3:    return x - y;
         4'd5:    return x ^ y;
         4'd6:    return x << 4;
         4'd7:    return x >> 4;
         4'd8:    return ~x;
         4'd9:    return y - x;
         4'd10:   return y;
         default: return 32'd0;
      endcase
   endfunction
   assign alu_z = alu_model(alu_op, alu_x, alu_y);
   alu_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .err_count(err_count)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, busy, err_count} !== 43'd0) begin
         errors++;
         $display("FAIL reset_rsp: got v=%b id=%b err=%b data=%0h busy=%b cnt=%0d, exp all zero", rsp_valid, rsp_id, rsp_err, rsp_data, busy, err_count);
      end
      checks++;
      if ({alu_op, alu_x, alu_y, req0_ready, req1_ready} !== 70'd0) begin
         errors++;
         $display("FAIL reset_alu: got op=%0h x=%0h y=%0h rdy=%b%b, exp all zero", alu_op, alu_x, alu_y, req0_ready, req1_ready);
      end
   endtask
   task automatic test_basic();
      req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd5; req0_b = 32'd3; rsp_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b100) begin
         errors++;
         $display("FAIL basic_accept: got rdy0/rdy1/busy=%b, exp 100", {req0_ready, req1_ready, busy});
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if ({alu_op, alu_x, alu_y, busy, rsp_valid} !== {4'd2, 32'd5, 32'd3, 2'b10}) begin
         errors++;
         $display("FAIL basic_exec: got op=%0h x=%0d y=%0d busy=%b v=%b, exp op=2 x=5 y=3 busy=1 v=0", alu_op, alu_x, alu_y, busy, rsp_valid);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, 32'd8}) begin
         errors++;
         $display("FAIL basic_rsp: got v=%b id=%b err=%b data=%0d, exp v=1 id=0 err=0 data=8", rsp_valid, rsp_id, rsp_err, rsp_data);
      end
      tick();
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL basic_idle: got busy=%b v=%b, exp 0 0", busy, rsp_valid);
      end
   endtask
   task automatic test_round_robin();
      logic e;
      do_reset();
      req0_op = 4'd2; req0_a = 32'd1;  req0_b = 32'd1;
      req1_op = 4'd2; req1_a = 32'd10; req1_b = 32'd20;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = (i % 2) == 1;
         #1;
         checks++;
         if ({busy, req0_ready, req1_ready} !== {1'b0, !e, e}) begin
            errors++;
            $display("FAIL rr_grant%0d: got busy/rdy0/rdy1=%b, exp %b", i, {busy, req0_ready, req1_ready}, {1'b0, !e, e});
         end
         tick();
         checks++;
         if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL rr_exec%0d: got busy/v/rdy0/rdy1=%b, exp 1000", i, {busy, rsp_valid, req0_ready, req1_ready});
         end
         tick();
         checks++;
         if ({busy, rsp_valid, rsp_id, rsp_data} !== {2'b11, e, e ? 32'd30 : 32'd2}) begin
            errors++;
            $display("FAIL rr_rsp%0d: got busy=%b v=%b id=%b data=%0d, exp busy=1 v=1 id=%b data=%0d", i, busy, rsp_valid, rsp_id, rsp_data, e, e ? 30 : 2);
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask
   task automatic test_illegal();
      req0_op = 4'd2;
      req1_valid = 1'b1; req1_op = 4'd11; req1_a = 32'd7; req1_b = 32'd9; rsp_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL ill_accept: got rdy0/rdy1=%b, exp 01", {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, err_count} !== {3'b111, 32'd0, 8'd1}) begin
         errors++;
         $display("FAIL ill_rsp: got v=%b id=%b err=%b data=%0h cnt=%0d, exp v=1 id=1 err=1 data=0 cnt=1", rsp_valid, rsp_id, rsp_err, rsp_data, err_count);
      end
      checks++;
      if ({alu_op, alu_x, alu_y} !== {4'd2, 32'd10, 32'd20}) begin
         errors++;
         $display("FAIL ill_alu_hold: got op=%0h x=%0d y=%0d, exp op=2 x=10 y=20", alu_op, alu_x, alu_y);
      end
      tick();
      req1_op = 4'd4;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, err_count} !== {2'b11, 8'd2}) begin
         errors++;
         $display("FAIL ill_op4: got v=%b err=%b cnt=%0d, exp v=1 err=1 cnt=2", rsp_valid, rsp_err, err_count);
      end
      tick();
      req1_op = 4'd12;
      tick();
      checks++;
      if ({rsp_valid, rsp_err, err_count} !== {2'b11, 8'd3}) begin
         errors++;
         $display("FAIL ill_op12: got v=%b err=%b cnt=%0d, exp v=1 err=1 cnt=3", rsp_valid, rsp_err, err_count);
      end
      tick();
      req1_op = 4'd15;
      for (int i = 0; i < 256; i++) begin
         tick();
         tick();
      end
      req1_valid = 1'b0;
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL ill_saturate: got cnt=%0d, exp 255", err_count);
      end
   endtask
   task automatic test_backpressure();
      req0_op = 4'd3; req0_a = 32'd100; req0_b = 32'd1;
      req1_op = 4'd5; req1_a = 32'd6;   req1_b = 32'd3;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL bp_accept: got rdy0/rdy1=%b, exp 10", {req0_ready, req1_ready});
      end
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready} !== {3'b100, 32'd99, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b id=%b err=%b data=%0d rdy=%b%b, exp v=1 id=0 err=0 data=99 rdy=00", i, rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready);
         end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_data, req0_ready, req1_ready} !== {1'b1, 32'd99, 2'b00}) begin
         errors++;
         $display("FAIL bp_consume: got v=%b data=%0d rdy=%b%b, exp v=1 data=99 rdy=00", rsp_valid, rsp_data, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL bp_next: got rdy0/rdy1/busy=%b, exp 010", {req0_ready, req1_ready, busy});
      end
      tick();
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b110, 32'd5}) begin
         errors++;
         $display("FAIL bp_rsp2: got v=%b id=%b err=%b data=%0d, exp v=1 id=1 err=0 data=5", rsp_valid, rsp_id, rsp_err, rsp_data);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask
   task automatic test_reset_exec();
      req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
      tick();
      req0_valid = 1'b0;
      checks++;
      if ({busy, alu_x} !== {1'b1, 32'd1}) begin
         errors++;
         $display("FAIL rx_exec: got busy=%b x=%0d, exp busy=1 x=1", busy, alu_x);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, busy, rsp_id, rsp_err, rsp_data, alu_op, alu_x, alu_y, err_count} !== 111'd0) begin
         errors++;
         $display("FAIL rx_state: got v=%b busy=%b id=%b err=%b data=%0h op=%0h x=%0h y=%0h cnt=%0d, exp all zero", rsp_valid, busy, rsp_id, rsp_err, rsp_data, alu_op, alu_x, alu_y, err_count);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL rx_grant: got rdy0/rdy1=%b, exp 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL rx_no_rsp: got v=%b busy=%b, exp 0 0", rsp_valid, busy);
      end
   endtask
   task automatic test_all_ops();
      logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
      logic [31:0] exp [10] = '{32'h30, 32'hFC, 32'h12C, 32'hB4, 32'hCC, 32'hF00, 32'hF, 32'hFFFFFF0F, 32'hFFFFFF4C, 32'h3C};
      logic r;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         r = (i % 2) == 1;
         req0_valid = !r; req0_op = ops[i]; req0_a = r ? 32'd0 : 32'hF0; req0_b = r ? 32'd0 : 32'h3C;
         req1_valid = r;  req1_op = ops[i]; req1_a = r ? 32'hF0 : 32'd0; req1_b = r ? 32'h3C : 32'd0;
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== {!r, r}) begin
            errors++;
            $display("FAIL ops_accept%0d: got rdy0/rdy1=%b, exp %b", i, {req0_ready, req1_ready}, {!r, r});
         end
         tick();
         req0_valid = 1'b0; req1_valid = 1'b0;
         tick();
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, r, 1'b0, exp[i]}) begin
            errors++;
            $display("FAIL ops_rsp op=%0d: got v=%b id=%b err=%b data=%0h, exp v=1 id=%b err=0 data=%0h", ops[i], rsp_valid, rsp_id, rsp_err, rsp_data, r, exp[i]);
         end
         tick();
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_illegal();
      test_backpressure();
      test_reset_exec();
      test_all_ops();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
